// File: rtl/or1200_ibus_pkg.sv
// Shared types and constants for the or1200 instruction/data bus arbiter.
// OR1200_IBUS_ARB_FAIR_EN selects the fairness build; the default here is STARVE_LIMIT_DEF.
package or1200_ibus_pkg;

  localparam int AW_DEF           = 32;
  localparam int DW_DEF           = 32;
  localparam int STARVE_LIMIT_DEF = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GNT_I = 2'd1,
    GNT_D = 2'd2
  } arb_state_e;

  localparam logic [1:0] GNT_NONE  = 2'b00;
  localparam logic [1:0] GNT_FETCH = 2'b01;
  localparam logic [1:0] GNT_DATA  = 2'b10;

  function automatic logic [1:0] state_to_gnt(input arb_state_e s);
    case (s)
      GNT_I:   return GNT_FETCH;
      GNT_D:   return GNT_DATA;
      default: return GNT_NONE;
    endcase
  endfunction

endpackage

// File: rtl/or1200_ibus_arb_if.sv
// Signal bundle around the arbiter: fetch port, data port, shared bus and grant.
// slave = arbiter side, master = surrounding CPU/bus environment.
interface or1200_ibus_arb_if #(
  parameter int AW = or1200_ibus_pkg::AW_DEF,
  parameter int DW = or1200_ibus_pkg::DW_DEF
) ();

  logic            icpu_cyc_i, icpu_stb_i, icpu_cab_i;
  logic [AW-1:0]   icpu_adr_i;
  logic [DW-1:0]   icpu_dat_o;
  logic            icpu_ack_o, icpu_err_o;

  logic            dcpu_cyc_i, dcpu_stb_i, dcpu_we_i, dcpu_cab_i;
  logic [DW/8-1:0] dcpu_sel_i;
  logic [AW-1:0]   dcpu_adr_i;
  logic [DW-1:0]   dcpu_dat_i;
  logic [DW-1:0]   dcpu_dat_o;
  logic            dcpu_ack_o, dcpu_err_o;

  logic            bus_cyc_o, bus_stb_o, bus_we_o, bus_cab_o;
  logic [DW/8-1:0] bus_sel_o;
  logic [AW-1:0]   bus_adr_o;
  logic [DW-1:0]   bus_dat_o;
  logic [DW-1:0]   bus_dat_i;
  logic            bus_ack_i, bus_err_i;

  logic [1:0]      gnt_o;

  modport slave (
    input  icpu_cyc_i, icpu_stb_i, icpu_cab_i, icpu_adr_i,
    output icpu_dat_o, icpu_ack_o, icpu_err_o,
    input  dcpu_cyc_i, dcpu_stb_i, dcpu_we_i, dcpu_cab_i, dcpu_sel_i, dcpu_adr_i, dcpu_dat_i,
    output dcpu_dat_o, dcpu_ack_o, dcpu_err_o,
    output bus_cyc_o, bus_stb_o, bus_we_o, bus_cab_o, bus_sel_o, bus_adr_o, bus_dat_o,
    input  bus_dat_i, bus_ack_i, bus_err_i,
    output gnt_o
  );

  modport master (
    output icpu_cyc_i, icpu_stb_i, icpu_cab_i, icpu_adr_i,
    input  icpu_dat_o, icpu_ack_o, icpu_err_o,
    output dcpu_cyc_i, dcpu_stb_i, dcpu_we_i, dcpu_cab_i, dcpu_sel_i, dcpu_adr_i, dcpu_dat_i,
    input  dcpu_dat_o, dcpu_ack_o, dcpu_err_o,
    input  bus_cyc_o, bus_stb_o, bus_we_o, bus_cab_o, bus_sel_o, bus_adr_o, bus_dat_o,
    output bus_dat_i, bus_ack_i, bus_err_i,
    input  gnt_o
  );

endinterface

// File: rtl/or1200_ibus_starve_cnt.sv
// Saturating count of data grants taken while fetch was waiting.
// Only used when OR1200_IBUS_ARB_FAIR_EN is defined.
module or1200_ibus_starve_cnt #(
  parameter int LIMIT = or1200_ibus_pkg::STARVE_LIMIT_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic inc_i,
  input  logic clr_i,
  output logic sat_o
);

  localparam logic [3:0] LIMIT_C = 4'(LIMIT);

  logic [3:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = 4'd0;
    end else if (inc_i && (cnt_q != LIMIT_C)) begin
      cnt_d = cnt_q + 4'd1;
    end else begin
      cnt_d = cnt_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) cnt_q <= 4'd0;
    else     cnt_q <= cnt_d;
  end

  assign sat_o = (cnt_q == LIMIT_C);

endmodule

// File: rtl/or1200_ibus_arb.sv
// Two-master (fetch/data) arbiter for one shared Wishbone-style bus; data has priority.
// Define OR1200_IBUS_ARB_FAIR_EN to let fetch win after STARVE_LIMIT consecutive data grants.
module or1200_ibus_arb
  import or1200_ibus_pkg::*;
(
  input logic              clk,
  input logic              rst,
  or1200_ibus_arb_if.slave bif
);

`ifdef OR1200_IBUS_ARB_FAIR_EN
  parameter int STARVE_LIMIT = STARVE_LIMIT_DEF;
`endif

  arb_state_e state_q, state_d;
  logic       fair_ovr_s;

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (bif.dcpu_cyc_i && !(fair_ovr_s && bif.icpu_cyc_i)) state_d = GNT_D;
        else if (bif.icpu_cyc_i)                               state_d = GNT_I;
        else                                                   state_d = IDLE;
      end
      GNT_I:   state_d = bif.icpu_cyc_i ? GNT_I : IDLE;
      GNT_D:   state_d = bif.dcpu_cyc_i ? GNT_D : IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

`ifdef OR1200_IBUS_ARB_FAIR_EN
  logic starve_inc_s, starve_clr_s;

  assign starve_inc_s = (state_q == IDLE) && (state_d == GNT_D) && bif.icpu_cyc_i;
  assign starve_clr_s = (state_q == IDLE) && (state_d == GNT_I);

  or1200_ibus_starve_cnt #(.LIMIT(STARVE_LIMIT)) u_starve_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc_i (starve_inc_s),
    .clr_i (starve_clr_s),
    .sat_o (fair_ovr_s)
  );
`else
  assign fair_ovr_s = 1'b0;
`endif

  // Owner selection comes from the registered state; ack/err/data paths stay combinational.
  always_comb begin
    bif.bus_cyc_o  = 1'b0;
    bif.bus_stb_o  = 1'b0;
    bif.bus_we_o   = 1'b0;
    bif.bus_cab_o  = 1'b0;
    bif.bus_sel_o  = '0;
    bif.bus_adr_o  = '0;
    bif.bus_dat_o  = '0;
    bif.icpu_ack_o = 1'b0;
    bif.icpu_err_o = 1'b0;
    bif.dcpu_ack_o = 1'b0;
    bif.dcpu_err_o = 1'b0;
    case (state_q)
      GNT_I: begin
        bif.bus_cyc_o  = bif.icpu_cyc_i;
        bif.bus_stb_o  = bif.icpu_stb_i;
        bif.bus_cab_o  = bif.icpu_cab_i;
        bif.bus_sel_o  = '1;
        bif.bus_adr_o  = bif.icpu_adr_i;
        bif.icpu_ack_o = bif.bus_ack_i;
        bif.icpu_err_o = bif.bus_err_i;
      end
      GNT_D: begin
        bif.bus_cyc_o  = bif.dcpu_cyc_i;
        bif.bus_stb_o  = bif.dcpu_stb_i;
        bif.bus_we_o   = bif.dcpu_we_i;
        bif.bus_cab_o  = bif.dcpu_cab_i;
        bif.bus_sel_o  = bif.dcpu_sel_i;
        bif.bus_adr_o  = bif.dcpu_adr_i;
        bif.bus_dat_o  = bif.dcpu_dat_i;
        bif.dcpu_ack_o = bif.bus_ack_i;
        bif.dcpu_err_o = bif.bus_err_i;
      end
      default: begin
        bif.bus_cyc_o = 1'b0;
      end
    endcase
  end

  assign bif.gnt_o      = state_to_gnt(state_q);
  assign bif.icpu_dat_o = bif.bus_dat_i;
  assign bif.dcpu_dat_o = bif.bus_dat_i;

endmodule
